// File: rtl/la_clkmux4_ctrl_pkg.sv
// rtl/la_clkmux4_ctrl_pkg.sv - shared state encoding and helpers for the 4-input clock-mux controller
package la_clkmux4_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BREAK = 2'd1,
    MAKE  = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [3:0] src_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // Down-counter width: enough for the longer of the two phases, never below 1 bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/la_clkctrl_timer.sv
// rtl/la_clkctrl_timer.sv - loadable down-counter that holds at zero
module la_clkctrl_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/la_clkmux4_ctrl.sv
// rtl/la_clkmux4_ctrl.sv - break-before-make select sequencer with automatic fail-over
module la_clkmux4_ctrl
  import la_clkmux4_ctrl_pkg::*;
#(
  parameter int DEFAULT_SEL   = 0,
  parameter int FALLBACK_SEL  = 0,
  parameter int BREAK_CYCLES  = 8,
  parameter int SETTLE_CYCLES = 8,
  parameter int FAILOVER      = 1
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       req_valid,
  input  logic [1:0] req_src,
  output logic       req_ready,
  input  logic [3:0] clk_ok,
  output logic [3:0] sel,
  output logic [1:0] cur_src,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int CNT_W = cnt_width(BREAK_CYCLES, SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] BRK_LOAD = CNT_W'(BREAK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SET_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [1:0] DEF_IDX = 2'(DEFAULT_SEL);
  localparam logic [1:0] FB_IDX  = 2'(FALLBACK_SEL);

  if (DEFAULT_SEL < 0 || DEFAULT_SEL > 3) begin : g_bad_default
    $error("DEFAULT_SEL must be 0..3");
  end
  if (FALLBACK_SEL < 0 || FALLBACK_SEL > 3) begin : g_bad_fallback
    $error("FALLBACK_SEL must be 0..3");
  end
  if (BREAK_CYCLES < 1 || SETTLE_CYCLES < 1) begin : g_bad_cycles
    $error("BREAK_CYCLES and SETTLE_CYCLES must be >= 1");
  end
  if (FAILOVER != 0 && FAILOVER != 1) begin : g_bad_failover
    $error("FAILOVER must be 0 or 1");
  end

  state_t     r_state, w_state_nxt;
  logic [3:0] r_sel, w_sel_nxt;
  logic [1:0] r_cur_src, w_cur_nxt;
  logic [1:0] r_tgt, w_tgt_nxt;
  logic       r_busy, r_done, r_err;
  logic       w_done_nxt, w_err_nxt;
  logic       w_load, w_en, w_zero, w_failover;
  logic [CNT_W-1:0] w_load_val;

  la_clkctrl_timer #(.W(CNT_W)) u_timer (
    .clk        (clk),
    .nreset     (nreset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_en       (w_en),
    .o_zero     (w_zero)
  );

  // Fail-over only moves to a live fallback; a dead fallback leaves the controller idle.
  assign w_failover = (FAILOVER != 0) && (r_state == IDLE) && !clk_ok[r_cur_src] &&
                      (r_cur_src != FB_IDX) && clk_ok[FB_IDX];
  assign req_ready  = (r_state == IDLE) && !w_failover;

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_cur_nxt   = r_cur_src;
    w_tgt_nxt   = r_tgt;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_load      = 1'b0;
    w_load_val  = '0;
    w_en        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_failover) begin
          w_err_nxt   = 1'b1;
          w_tgt_nxt   = FB_IDX;
          w_sel_nxt   = '0;
          w_load      = 1'b1;
          w_load_val  = BRK_LOAD;
          w_state_nxt = BREAK;
        end else if (req_valid) begin
          if (!clk_ok[req_src]) begin
            w_err_nxt = 1'b1;
          end else if (req_src == r_cur_src) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = DONE;
          end else begin
            w_tgt_nxt   = req_src;
            w_sel_nxt   = '0;
            w_load      = 1'b1;
            w_load_val  = BRK_LOAD;
            w_state_nxt = BREAK;
          end
        end
      end
      BREAK: begin
        if (w_zero) begin
          w_sel_nxt   = src_onehot(r_tgt);
          w_load      = 1'b1;
          w_load_val  = SET_LOAD;
          w_state_nxt = MAKE;
        end else begin
          w_en = 1'b1;
        end
      end
      MAKE: begin
        if (w_zero) begin
          w_cur_nxt   = r_tgt;
          w_done_nxt  = 1'b1;
          w_state_nxt = DONE;
        end else begin
          w_en = 1'b1;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state   <= IDLE;
      r_sel     <= src_onehot(DEF_IDX);
      r_cur_src <= DEF_IDX;
      r_tgt     <= DEF_IDX;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_sel     <= w_sel_nxt;
      r_cur_src <= w_cur_nxt;
      r_tgt     <= w_tgt_nxt;
      r_busy    <= (w_state_nxt != IDLE);
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
    end
  end

  assign sel     = r_sel;
  assign cur_src = r_cur_src;
  assign busy    = r_busy;
  assign done    = r_done;
  assign err     = r_err;

endmodule

// File: tb/tb_la_clkmux4_ctrl.sv
// tb/tb_la_clkmux4_ctrl.sv - self-checking bench for la_clkmux4_ctrl
module tb_la_clkmux4_ctrl;
  import la_clkmux4_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       nreset;
  logic       req_valid;
  logic [1:0] req_src;
  logic       req_ready;
  logic [3:0] clk_ok;
  logic [3:0] sel;
  logic [1:0] cur_src;
  logic       busy, done, err;

  int n_cmp = 0;
  int n_bad = 0;
  int vec_idx = 0;

  typedef struct {
    logic       rv;
    logic [1:0] rs;
    logic [3:0] ok;
    logic [3:0] sel;
    logic [1:0] cur;
    logic       busy;
    logic       done;
    logic       err;
    logic       rdy;
  } vec_t;

  vec_t vecs[$];

  la_clkmux4_ctrl #(
    .DEFAULT_SEL   (2),
    .FALLBACK_SEL  (0),
    .BREAK_CYCLES  (8),
    .SETTLE_CYCLES (8),
    .FAILOVER      (1)
  ) u_dut (
    .clk       (clk),
    .nreset    (nreset),
    .req_valid (req_valid),
    .req_src   (req_src),
    .req_ready (req_ready),
    .clk_ok    (clk_ok),
    .sel       (sel),
    .cur_src   (cur_src),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    n_cmp++;
    if ($countones(sel) > 1) begin
      n_bad++;
      $display("FAIL sel_multihot: got %b, expected at most one bit set", sel);
    end
  end

  task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s [%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic push(input logic rv, input logic [1:0] rs, input logic [3:0] ok,
                      input logic [3:0] s, input logic [1:0] c, input logic b,
                      input logic d, input logic e, input logic r);
    vec_t v;
    v.rv = rv; v.rs = rs; v.ok = ok; v.sel = s; v.cur = c;
    v.busy = b; v.done = d; v.err = e; v.rdy = r;
    vecs.push_back(v);
  endtask

  // Accept cycle plus the 17 cycles up to and including the done pulse (BREAK=SETTLE=8).
  task automatic add_seq(input logic rv0, input logic rvh, input logic [1:0] rs, input logic [3:0] ok,
                         input logic [3:0] old_sel, input logic [1:0] old_cur,
                         input logic [1:0] tgt, input logic fo);
    logic [3:0] nsel;
    nsel = 4'b0001 << tgt;
    push(rv0, rs, ok, old_sel, old_cur, 1'b0, 1'b0, 1'b0, !fo);
    for (int k = 1; k <= 17; k++) begin
      push(rvh, rs, ok, (k <= 8) ? 4'b0000 : nsel, (k == 17) ? tgt : old_cur,
           1'b1, (k == 17), (fo && k == 1), 1'b0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vecs();
    vec_t v;
    while (vecs.size() > 0) begin
      v = vecs.pop_front();
      req_valid = v.rv;
      req_src   = v.rs;
      clk_ok    = v.ok;
      #1;
      chk("sel",     vec_idx, sel,               v.sel);
      chk("cur_src", vec_idx, {2'b00, cur_src},  {2'b00, v.cur});
      chk("busy",    vec_idx, {3'b000, busy},    {3'b000, v.busy});
      chk("done",    vec_idx, {3'b000, done},    {3'b000, v.done});
      chk("err",     vec_idx, {3'b000, err},     {3'b000, v.err});
      chk("ready",   vec_idx, {3'b000, req_ready}, {3'b000, v.rdy});
      vec_idx++;
      step();
    end
  endtask

  initial begin
    int seen_done;
    nreset    = 1'b0;
    req_valid = 1'b0;
    req_src   = 2'd0;
    clk_ok    = 4'b1111;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_sel",  0, sel,               4'b0100);
    chk("rst_cur",  0, {2'b00, cur_src},  4'd2);
    chk("rst_busy", 0, {3'b000, busy},    4'd0);
    chk("rst_done", 0, {3'b000, done},    4'd0);
    chk("rst_err",  0, {3'b000, err},     4'd0);
    nreset = 1'b1;
    #1;
    chk("rel_ready", 0, {3'b000, req_ready}, 4'd1);
    chk("rel_sel",   0, sel,                 4'b0100);
    chk("rel_state", 0, {2'b00, u_dut.r_state}, {2'b00, IDLE});
    step();

    // 2 -> 1, reject dead 3, same-source 1, 1 -> 2, fail-over to 0 with held request, then 0 -> 3
    add_seq(1'b1, 1'b0, 2'd1, 4'b1111, 4'b0100, 2'd2, 2'd1, 1'b0);
    push(1'b1, 2'd3, 4'b0111, 4'b0010, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    push(1'b0, 2'd0, 4'b1111, 4'b0010, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1);
    push(1'b1, 2'd1, 4'b1111, 4'b0010, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    push(1'b0, 2'd0, 4'b1111, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    add_seq(1'b1, 1'b0, 2'd2, 4'b1111, 4'b0010, 2'd1, 2'd2, 1'b0);
    add_seq(1'b1, 1'b1, 2'd3, 4'b1011, 4'b0100, 2'd2, 2'd0, 1'b1);
    add_seq(1'b1, 1'b0, 2'd3, 4'b1011, 4'b0001, 2'd0, 2'd3, 1'b0);
    push(1'b0, 2'd0, 4'b1111, 4'b1000, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    run_vecs();

    // Reset in the middle of MAKE while switching 3 -> 1
    req_valid = 1'b1;
    req_src   = 2'd1;
    clk_ok    = 4'b1111;
    #1;
    chk("mr_accept_ready", 0, {3'b000, req_ready}, 4'd1);
    step();
    req_valid = 1'b0;
    repeat (10) step();
    chk("mr_make_sel",  0, sel,            4'b0010);
    chk("mr_make_busy", 0, {3'b000, busy}, 4'd1);
    nreset = 1'b0;
    #1;
    chk("mr_rst_sel",  0, sel,              4'b0100);
    chk("mr_rst_cur",  0, {2'b00, cur_src}, 4'd2);
    chk("mr_rst_busy", 0, {3'b000, busy},   4'd0);
    chk("mr_rst_done", 0, {3'b000, done},   4'd0);
    repeat (2) step();
    chk("mr_hold_sel", 0, sel, 4'b0100);
    nreset = 1'b1;
    #1;
    chk("mr_rel_ready", 0, {3'b000, req_ready}, 4'd1);
    seen_done = 0;
    repeat (20) begin
      step();
      if (done) seen_done++;
    end
    chk("mr_no_done", 0, 4'(seen_done), 4'd0);
    chk("mr_idle_sel", 0, sel, 4'b0100);

    add_seq(1'b1, 1'b0, 2'd0, 4'b1111, 4'b0100, 2'd2, 2'd0, 1'b0);
    push(1'b0, 2'd0, 4'b1111, 4'b0001, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_vecs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
